// File: rtl/sync_arith_arbiter_29_if.sv
// ---------------------------------------------------------------------------
// sync_arith_arbiter_29_if
// Requester-side bus of the two-way arithmetic arbiter: request valid/ready
// with operands and opcode, response valid/ack, and the shared result/status.
//
// Signals (direction as seen by the arbiter, i.e. the slave modport):
//   i_reqN_valid       in   requester N has a request pending
//   i_reqN_A/B [M]     in   requester N operands
//   i_reqN_op  [4]     in   requester N opcode
//   o_reqN_ready       out  one-cycle accept pulse for requester N
//   o_rspN_valid       out  response for requester N available
//   i_rspN_ack         in   requester N consumes the response
//   o_result   [M]     out  shared response result (qualified by o_rspN_valid)
//   o_status   [4]     out  shared response status (qualified by o_rspN_valid)
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface sync_arith_arbiter_29_if #(
    parameter int M = 32
);
    logic         i_req0_valid;
    logic [M-1:0] i_req0_A;
    logic [M-1:0] i_req0_B;
    logic [3:0]   i_req0_op;
    logic         o_req0_ready;
    logic         o_rsp0_valid;
    logic         i_rsp0_ack;

    logic         i_req1_valid;
    logic [M-1:0] i_req1_A;
    logic [M-1:0] i_req1_B;
    logic [3:0]   i_req1_op;
    logic         o_req1_ready;
    logic         o_rsp1_valid;
    logic         i_rsp1_ack;

    logic [M-1:0] o_result;
    logic [3:0]   o_status;

    modport master (
        output i_req0_valid, i_req0_A, i_req0_B, i_req0_op, i_rsp0_ack,
        output i_req1_valid, i_req1_A, i_req1_B, i_req1_op, i_rsp1_ack,
        input  o_req0_ready, o_rsp0_valid, o_req1_ready, o_rsp1_valid,
        input  o_result, o_status
    );

    modport slave (
        input  i_req0_valid, i_req0_A, i_req0_B, i_req0_op, i_rsp0_ack,
        input  i_req1_valid, i_req1_A, i_req1_B, i_req1_op, i_rsp1_ack,
        output o_req0_ready, o_rsp0_valid, o_req1_ready, o_rsp1_valid,
        output o_result, o_status
    );
endinterface

// File: rtl/sync_arith_arbiter_29.sv
// ---------------------------------------------------------------------------
// sync_arith_arbiter_29
// Round-robin arbiter/sequencer sharing one sync_arith_unit_29 between two
// requesters. One transaction is in flight at a time:
//   IDLE -> accept winner (ready pulse), latch operands
//   ISSUE -> unit inputs stable, load wait counter with LAT-1
//   WAIT -> count down, capture unit result/status at zero
//   RESP -> hold response to granted requester until its ack
// Ready pulse to response valid is LAT+2 cycles.
//
// Parameters: M (operand/result width), LAT (unit latency, 1..15).
// Ports:
//   clk              system clock
//   i_reset          asynchronous active-low reset
//   bus              requester handshake bus (slave modport)
//   o_unit_A/B [M]   operands to unit
//   o_unit_op  [4]   opcode to unit
//   i_unit_result[M] result from unit
//   i_unit_status[4] status from unit
//   o_busy           arbiter not in IDLE
// Optional feature macro: ARB_OPCHECK_EN -- opcodes above 4'b0011 are
// accepted but answered directly with result 0 / status 4'b1111 without
// driving the unit.
// ---------------------------------------------------------------------------
module sync_arith_arbiter_29 #(
    parameter int M   = 32,
    parameter int LAT = 1
) (
    input  logic                   clk,
    input  logic                   i_reset,
    sync_arith_arbiter_29_if.slave bus,
    output logic [M-1:0]           o_unit_A,
    output logic [M-1:0]           o_unit_B,
    output logic [3:0]             o_unit_op,
    input  logic [M-1:0]           i_unit_result,
    input  logic [3:0]             i_unit_status,
    output logic                   o_busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t       state_reg, state_next;
    logic         ptr_reg, ptr_next;       // preferred requester on a tie
    logic         grant_reg, grant_next;   // requester owning the transaction
    logic [3:0]   cnt_reg, cnt_next;
    logic [M-1:0] a_reg, a_next;
    logic [M-1:0] b_reg, b_next;
    logic [3:0]   op_reg, op_next;
    logic [M-1:0] result_reg, result_next;
    logic [3:0]   status_reg, status_next;

    // Per-requester views of the bus so the arbitration logic can index them
    logic [1:0]   req_valid;
    logic [1:0]   rsp_ack;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_valid;
    logic [M-1:0] req_a  [2];
    logic [M-1:0] req_b  [2];
    logic [3:0]   req_op [2];

    assign req_valid = {bus.i_req1_valid, bus.i_req0_valid};
    assign rsp_ack   = {bus.i_rsp1_ack, bus.i_rsp0_ack};
    assign req_a[0]  = bus.i_req0_A;
    assign req_a[1]  = bus.i_req1_A;
    assign req_b[0]  = bus.i_req0_B;
    assign req_b[1]  = bus.i_req1_B;
    assign req_op[0] = bus.i_req0_op;
    assign req_op[1] = bus.i_req1_op;

    logic win_any;
    logic win_id;
    logic reject;

    // Tie goes to the pointer; otherwise the single valid requester wins.
    assign win_any = |req_valid;
    assign win_id  = (&req_valid) ? ptr_reg : req_valid[1];

`ifdef ARB_OPCHECK_EN
    assign reject = (req_op[win_id] > 4'd3);
`else
    assign reject = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        grant_next  = grant_reg;
        cnt_next    = cnt_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        op_next     = op_reg;
        result_next = result_reg;
        status_next = status_reg;
        req_ready   = 2'b00;

        case (state_reg)
            IDLE: begin
                // Ready is combinational from valid; qualifying it with the
                // reset keeps it low while the block is held in reset.
                if (win_any && i_reset) begin
                    req_ready  = win_id ? 2'b10 : 2'b01;
                    grant_next = win_id;
                    if (reject) begin
                        result_next = '0;
                        status_next = 4'b1111;
                        state_next  = RESP;
                    end else begin
                        a_next     = req_a[win_id];
                        b_next     = req_b[win_id];
                        op_next    = req_op[win_id];
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_next   = 4'(LAT - 1);
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    result_next = i_unit_result;
                    status_next = i_unit_status;
                    state_next  = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                // Only the owner's ack ends the transaction.
                if (rsp_ack[grant_reg]) begin
                    ptr_next   = ~grant_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg  <= IDLE;
            ptr_reg    <= 1'b0;
            grant_reg  <= 1'b0;
            cnt_reg    <= 4'd0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= 4'd0;
            result_reg <= '0;
            status_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            grant_reg  <= grant_next;
            cnt_reg    <= cnt_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            op_reg     <= op_next;
            result_reg <= result_next;
            status_reg <= status_next;
        end
    end

    assign bus.o_req0_ready = req_ready[0];
    assign bus.o_req1_ready = req_ready[1];
    assign bus.o_rsp0_valid = rsp_valid[0];
    assign bus.o_rsp1_valid = rsp_valid[1];
    assign bus.o_result     = result_reg;
    assign bus.o_status     = status_reg;
    assign o_unit_A         = a_reg;
    assign o_unit_B         = b_reg;
    assign o_unit_op        = op_reg;
    assign o_busy           = (state_reg != IDLE);
endmodule
